// File: rtl/regfile_sb.sv
// Parametrised register file: NRD combinational read ports, one byte-enabled write
// port with optional same-cycle forwarding, and a per-register busy scoreboard.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int ABITS    = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ABITS-1:0]  ra,
    output logic [NRD*WIDTH-1:0]  rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we3,
    input  logic [ABITS-1:0]      wa3,
    input  logic [WIDTH-1:0]      wd3,
    input  logic [WIDTH/8-1:0]    wbe,
    input  logic                  rsv,
    input  logic [ABITS-1:0]      rsva,
    output logic [2**ABITS-1:0]   busy
);

    localparam int DEPTH  = 2**ABITS;
    localparam int NBYTES = WIDTH/8;

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_zero;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0]  base,
        input logic [WIDTH-1:0]  data,
        input logic [NBYTES-1:0] be
    );
        logic [WIDTH-1:0] res;
        res = base;
        for (int j = 0; j < NBYTES; j++) begin
            if (be[j]) res[8*j +: 8] = data[8*j +: 8];
        end
        return res;
    endfunction

    assign wr_zero = (ZERO_REG != 0) && (wa3 == '0);

    // Reserve is applied after the write-clear so a new producer issued on the
    // retiring producer's register keeps it busy.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        if (we3) begin
            if (!wr_zero) rf_d[wa3] = merge_bytes(rf_q[wa3], wd3, wbe);
            busy_d[wa3] = 1'b0;
        end
        if (rsv) busy_d[rsva] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) rf_q[n] <= '0;
            busy_q <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ABITS-1:0] addr;
        logic [WIDTH-1:0] base;
        logic [WIDTH-1:0] merged;
        logic             zero_sup;
        logic             hit;

        assign addr     = ra[p*ABITS +: ABITS];
        assign base     = rf_q[addr];
        assign merged   = merge_bytes(base, wd3, wbe);
        assign zero_sup = (ZERO_REG != 0) && (addr == '0);
        assign hit      = (BYPASS != 0) && we3 && (wa3 == addr);

        // Zero register reads 0 even before the first reset has cleared the array.
        assign rd[p*WIDTH +: WIDTH] = zero_sup ? '0 : (hit ? merged : base);
        assign rbusy[p] = zero_sup ? 1'b0 :
                          (hit ? (rsv && (rsva == addr)) : busy_q[addr]);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NRD=4, BYPASS=1, ZERO_REG=1) with immediate-assertion checks.
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int ABITS = 5;
    localparam int NRD   = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NRD*ABITS-1:0] ra = '0;
    logic [NRD*WIDTH-1:0] rd;
    logic [NRD-1:0]       rbusy;
    logic                 we3 = 1'b0;
    logic [ABITS-1:0]     wa3 = '0;
    logic [WIDTH-1:0]     wd3 = '0;
    logic [WIDTH/8-1:0]   wbe = '0;
    logic                 rsv = 1'b0;
    logic [ABITS-1:0]     rsva = '0;
    logic [31:0]          busy;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb #(.WIDTH(WIDTH), .ABITS(ABITS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we3(we3), .wa3(wa3), .wd3(wd3), .wbe(wbe),
        .rsv(rsv), .rsva(rsva), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] a3);
        ra = {a3, a2, a1, a0};
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset, then sweep every address on all ports
        tick();
        reset = 1'b0;
        #1;
        check("rst_busy", 128'(busy), 128'h0);
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(a), 5'(a), 5'(a));
            check("rst_rd", rd, 128'h0);
            check("rst_rbusy", 128'(rbusy), 128'h0);
        end

        // full write then byte-0 write with same-cycle forwarding
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF; wbe = 4'b1111;
        set_ra(5'd5, 5'd5, 5'd5, 5'd5);
        check("byp_full", rd, {4{32'hDEADBEEF}});
        tick();
        wd3 = 32'h000000AA; wbe = 4'b0001;
        #1;
        check("byp_byte", rd[31:0], 128'hDEADBEAA);
        tick();
        we3 = 1'b0;
        #1;
        check("r5_merged", rd[31:0], 128'hDEADBEAA);

        // zero register ignores writes and reservations
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h12345678; wbe = 4'b1111; rsv = 1'b1; rsva = 5'd0;
        set_ra(5'd0, 5'd0, 5'd0, 5'd0);
        check("r0_rd_same", rd, 128'h0);
        check("r0_rbusy_same", 128'(rbusy), 128'h0);
        tick();
        we3 = 1'b0; rsv = 1'b0;
        #1;
        check("r0_rd", rd, 128'h0);
        check("r0_busy", 128'(busy), 128'h0);
        check("r0_rbusy", 128'(rbusy), 128'h0);

        // scoreboard on r9
        rsv = 1'b1; rsva = 5'd9;
        set_ra(5'd9, 5'd9, 5'd9, 5'd9);
        check("r9_pre", 128'(busy), 128'h0);
        tick();
        rsv = 1'b0;
        #1;
        check("r9_rsv_busy", 128'(busy), 128'h200);
        check("r9_rsv_rbusy", 128'(rbusy), 128'hF);
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h11111111; wbe = 4'b1111; rsv = 1'b1; rsva = 5'd9;
        #1;
        check("r9_wr_rsv_rbusy", 128'(rbusy), 128'hF);
        tick();
        rsv = 1'b0; wd3 = 32'h22222222; wbe = 4'b0011;
        #1;
        check("r9_still_busy", 128'(busy), 128'h200);
        check("r9_lone_rbusy", 128'(rbusy), 128'h0);
        check("r9_lone_rd", rd[31:0], 128'h11112222);
        tick();
        we3 = 1'b0;
        #1;
        check("r9_cleared", 128'(busy), 128'h0);
        check("r9_data", rd[31:0], 128'h11112222);

        // wbe=0 write still clears busy and changes no data
        rsv = 1'b1; rsva = 5'd12;
        tick();
        rsv = 1'b0;
        set_ra(5'd12, 5'd12, 5'd12, 5'd12);
        check("r12_busy", 128'(busy), 128'h1000);
        we3 = 1'b1; wa3 = 5'd12; wd3 = 32'hFFFFFFFF; wbe = 4'b0000;
        #1;
        check("r12_be0_rd", rd[31:0], 128'h0);
        check("r12_be0_rbusy", 128'(rbusy), 128'h0);
        tick();
        we3 = 1'b0;
        #1;
        check("r12_be0_busy", 128'(busy), 128'h0);
        check("r12_be0_data", rd[31:0], 128'h0);

        // all four ports alias the write address
        set_ra(5'd3, 5'd3, 5'd3, 5'd3);
        check("r3_old", rd, 128'h0);
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h55AA55AA; wbe = 4'b1111;
        #1;
        check("r3_byp4", rd, {4{32'h55AA55AA}});
        tick();
        we3 = 1'b0;
        #1;
        check("r3_after", rd, {4{32'h55AA55AA}});

        // independent addresses on each port
        set_ra(5'd5, 5'd9, 5'd3, 5'd0);
        check("mix_ports", rd, {32'h0, 32'h55AA55AA, 32'h11112222, 32'hDEADBEAA});

        // reset mid-operation discards that cycle's write and reservation
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h00000001; wbe = 4'b1111;
        tick();
        we3 = 1'b0; rsv = 1'b1; rsva = 5'd8;
        tick();
        rsv = 1'b0;
        set_ra(5'd7, 5'd8, 5'd10, 5'd5);
        check("pre_rst_rd7", rd[31:0], 128'h1);
        check("pre_rst_busy", 128'(busy), 128'h100);
        reset = 1'b1; we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hFFFFFFFF; rsv = 1'b1; rsva = 5'd10;
        tick();
        reset = 1'b0; we3 = 1'b0; rsv = 1'b0;
        #1;
        check("post_rst_rd", rd, 128'h0);
        check("post_rst_busy", 128'(busy), 128'h0);
        check("post_rst_rbusy", 128'(rbusy), 128'h0);
        set_ra(5'd3, 5'd9, 5'd0, 5'd0);
        check("post_rst_rd2", rd, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
